// File: rtl/eq_ctrl_pkg.sv
// Shared constants and FSM state type for the equalizer control path.
// Latency: n/a (declarations only).
// Backpressure: n/a. Used by spi_reg_loader and the register map.
package eq_ctrl_pkg;

  // Register bank layout: one configuration byte followed by ten 24-bit gains.
  localparam int NUM_REGS      = 31;
  localparam int CFG_ADDR      = 0;
  localparam int GAIN_BYTES    = 3;
  localparam int CMD_WRITE_BIT = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  // MSB-first shift: the newest bit enters at bit 0.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
    return {cur[6:0], bit_in};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with registered rise/fall pulses for one async pin.
// Latency: q after STAGES clk, rise/fall pulses one clk after q changes.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  assign q = chain[STAGES-1];

  // Synchronizer chain plus a delayed copy used to form registered edge pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~q_d;
      fall  <= ~chain[STAGES-1] & q_d;
    end
  end

endmodule

// File: rtl/spi_reg_loader.sv
// SPI mode-0 slave turning host frames (cmd byte + data bytes) into register byte writes.
// Latency: we rises SYNC_STAGES+2 clk after the sck pin edge carrying a byte's last bit.
// Backpressure: none; needs f_clk >= 8*f_sck. Optional macro SPI_MISO_ECHO_EN adds spi_miso echo.
module spi_reg_loader
  import eq_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_REGS    = eq_ctrl_pkg::NUM_REGS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
`ifdef SPI_MISO_ECHO_EN
  output logic                  spi_miso,
`endif
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            data_out,
  output logic                  busy,
  output logic                  err
);

  localparam logic [31:0] NUM_REGS_U = NUM_REGS;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  logic sck_rise, sck_fall, sck_sync;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .d(spi_sck), .q(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Edge outputs this block has no use for (sck_fall only matters with the echo).
  logic unused_edges;
`ifdef SPI_MISO_ECHO_EN
  assign unused_edges = &{1'b0, sck_sync, cs_rise, mosi_rise, mosi_fall};
`else
  assign unused_edges = &{1'b0, sck_sync, cs_rise, mosi_rise, mosi_fall, sck_fall};
`endif

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q;
  logic [7:0]            shift_q;
  logic [7:0]            next_byte;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [SYNC_STAGES:0]  settle_q;
  logic                  armed_q;
  logic                  cmd_ok;
  logic                  shift_en, byte_done, load_ptr, err_set, wr_set;

  assign next_byte = shift_in(shift_q, mosi_sync);
  assign cmd_ok    = next_byte[CMD_WRITE_BIT] && ({27'd0, next_byte[4:0]} < NUM_REGS_U);
  assign busy      = ~cs_sync;

  // A frame may only start once cs_n has been seen high with a settled synchronizer,
  // so a cs_n held low across reset release never opens a frame mid-stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      settle_q <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      armed_q  <= armed_q | (settle_q[SYNC_STAGES] & cs_sync);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; deasserted cs_n wins over any byte completing in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall && armed_q && !cs_sync) state_d = CMD;
      CMD: begin
        if (cs_sync)        state_d = IDLE;
        else if (byte_done) state_d = cmd_ok ? DATA : DISCARD;
      end
      DATA:    if (cs_sync) state_d = IDLE;
      DISCARD: if (cs_sync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode for the datapath.
  always_comb begin
    shift_en  = 1'b0;
    byte_done = 1'b0;
    load_ptr  = 1'b0;
    err_set   = 1'b0;
    wr_set    = 1'b0;
    if (!cs_sync && sck_rise && (state_q == CMD || state_q == DATA)) begin
      shift_en  = 1'b1;
      byte_done = (bit_cnt_q == 3'd7);
    end
    if (state_q == CMD && byte_done) begin
      load_ptr = cmd_ok;
      err_set  = !cmd_ok;
    end
    if (state_q == DATA && byte_done) wr_set = 1'b1;
  end

  // Shift register and bit counter; cleared whenever no frame is being received.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (state_q == IDLE || cs_sync) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      shift_q   <= next_byte;
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  // Write port and address pointer; addr/data_out hold between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we       <= 1'b0;
      err      <= 1'b0;
      addr     <= '0;
      data_out <= '0;
      ptr_q    <= '0;
    end else begin
      we  <= wr_set;
      err <= err_set;
      if (load_ptr) ptr_q <= ADDR_WIDTH'(next_byte[4:0]);
      if (wr_set) begin
        addr     <= ptr_q;
        data_out <= next_byte;
        ptr_q    <= (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
      end
    end
  end

`ifdef SPI_MISO_ECHO_EN
  logic [7:0] tx_q;
  logic [7:0] rx_last_q;
  logic       load_pend_q;

  // Echo shifter: the byte just received is loaded on the next sck fall, else shift MSB first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_q        <= '0;
      rx_last_q   <= '0;
      load_pend_q <= 1'b0;
    end else if (cs_sync) begin
      tx_q        <= '0;
      load_pend_q <= 1'b0;
    end else begin
      if (byte_done) begin
        rx_last_q   <= next_byte;
        load_pend_q <= 1'b1;
      end else if (sck_fall) begin
        tx_q        <= load_pend_q ? rx_last_q : {tx_q[6:0], 1'b0};
        load_pend_q <= 1'b0;
      end
    end
  end

  assign spi_miso = tx_q[7] & ~cs_sync;
`endif

endmodule

// File: tb/tb_spi_reg_loader.sv
// Directed bench for spi_reg_loader: SPI frames driven at f_clk = 8*f_sck.
// Latency: we expected SYNC_STAGES+2 clk after the last sck rising pin edge.
// Backpressure: none; a negedge monitor logs every write strobe and err cycle.
module tb_spi_reg_loader;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          spi_sck = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          we, busy, err;
  logic [AW-1:0] addr;
  logic [7:0]    data_out;
`ifdef SPI_MISO_ECHO_EN
  logic          spi_miso;
  logic [7:0]    miso_cap = 8'h00;
`endif

  spi_reg_loader #(.ADDR_WIDTH(AW), .NUM_REGS(31), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
`ifdef SPI_MISO_ECHO_EN
    .spi_miso(spi_miso),
`endif
    .we(we), .addr(addr), .data_out(data_out), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] wr_addr[$];
  logic [7:0]    wr_dat[$];
  int            wr_cyc[$];
  int            err_cnt = 0;
  int            back2back = 0;
  logic          we_prev = 1'b0;

  // Monitor samples away from the active edge.
  always @(negedge clk) begin
    if (we) begin
      wr_addr.push_back(addr);
      wr_dat.push_back(data_out);
      wr_cyc.push_back(cyc);
    end
    if (err) err_cnt = err_cnt + 1;
    if (we && we_prev) back2back = back2back + 1;
    we_prev = we;
  end

  int n_pass = 0;
  int n_total = 0;
  int last_rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    tick(4);
`ifdef SPI_MISO_ECHO_EN
    miso_cap = {miso_cap[6:0], spi_miso};
`endif
    spi_sck = 1'b1;
    last_rise_cyc = cyc;
    tick(4);
    spi_sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_dat.delete();
    wr_cyc.delete();
  endtask

  initial begin
    // Reset state.
    tick(3);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_addr", {27'd0, addr}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    tick(8);

    // Single write: cmd 0x81, data 0xA5.
    cs_begin();
    check("busy_hi", {31'd0, busy}, 32'd1);
    spi_byte(8'h81);
    spi_byte(8'hA5);
    cs_end();
    check("busy_lo", {31'd0, busy}, 32'd0);
    check("w1_cnt", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("w1_addr", {27'd0, wr_addr[0]}, 32'd1);
      check("w1_data", {24'd0, wr_dat[0]}, 32'hA5);
      check("w1_latency", wr_cyc[0] - last_rise_cyc, 32'd4);
    end
    check("w1_hold_addr", {27'd0, addr}, 32'd1);
    check("w1_hold_data", {24'd0, data_out}, 32'hA5);
    check("w1_err", err_cnt, 32'd0);
    clear_log();

    // Burst with pointer wrap 28,29,30,0.
    cs_begin();
    spi_byte(8'h9C);
    spi_byte(8'h11);
    spi_byte(8'h22);
    spi_byte(8'h33);
    spi_byte(8'h44);
    cs_end();
    check("burst_cnt", wr_addr.size(), 32'd4);
    if (wr_addr.size() == 4) begin
      check("burst_a0", {27'd0, wr_addr[0]}, 32'd28);
      check("burst_a1", {27'd0, wr_addr[1]}, 32'd29);
      check("burst_a2", {27'd0, wr_addr[2]}, 32'd30);
      check("burst_a3", {27'd0, wr_addr[3]}, 32'd0);
      check("burst_d0", {24'd0, wr_dat[0]}, 32'h11);
      check("burst_d3", {24'd0, wr_dat[3]}, 32'h44);
    end
    check("burst_err", err_cnt, 32'd0);
    clear_log();

    // Out-of-range write address, then a read command.
    cs_begin();
    spi_byte(8'h9F);
    spi_byte(8'h55);
    spi_byte(8'h66);
    cs_end();
    check("bad_addr_err", err_cnt, 32'd1);
    check("bad_addr_we", wr_addr.size(), 32'd0);
    cs_begin();
    spi_byte(8'h05);
    spi_byte(8'h77);
    cs_end();
    check("read_err", err_cnt, 32'd2);
    check("read_we", wr_addr.size(), 32'd0);

    // Abort after a partial byte.
    cs_begin();
    spi_byte(8'h80);
    spi_byte(8'h12);
    spi_bit(1'b1);
    spi_bit(1'b0);
    spi_bit(1'b1);
    spi_bit(1'b0);
    cs_end();
    check("abort_cnt", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("abort_addr", {27'd0, wr_addr[0]}, 32'd0);
      check("abort_data", {24'd0, wr_dat[0]}, 32'h12);
    end
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_err", err_cnt, 32'd2);
    clear_log();
    cs_begin();
    spi_byte(8'h83);
    spi_byte(8'h5A);
    cs_end();
    check("after_abort_cnt", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("after_abort_addr", {27'd0, wr_addr[0]}, 32'd3);
      check("after_abort_data", {24'd0, wr_dat[0]}, 32'h5A);
    end
    clear_log();

    // Reset in the middle of a data byte.
    cs_begin();
    spi_byte(8'h85);
    spi_byte(8'h42);
    spi_bit(1'b1);
    spi_bit(1'b1);
    spi_bit(1'b0);
    check("pre_rst_cnt", wr_addr.size(), 32'd1);
    clear_log();
    rst = 1'b0;
    #1;
    check("midrst_addr", {27'd0, addr}, 32'd0);
    check("midrst_data", {24'd0, data_out}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_we", {31'd0, we}, 32'd0);
    tick(3);
    rst = 1'b1;
    tick(10);
    // cs_n still low from before reset: no fresh falling edge, so nothing is written.
    spi_byte(8'h80);
    spi_byte(8'h7E);
    check("no_fresh_edge_we", wr_addr.size(), 32'd0);
    cs_end();
    cs_begin();
    spi_byte(8'h80);
    spi_byte(8'h7E);
    cs_end();
    check("post_rst_cnt", wr_addr.size(), 32'd1);
    if (wr_addr.size() == 1) begin
      check("post_rst_addr", {27'd0, wr_addr[0]}, 32'd0);
      check("post_rst_data", {24'd0, wr_dat[0]}, 32'h7E);
    end
    check("post_rst_err", err_cnt, 32'd2);
    clear_log();

`ifdef SPI_MISO_ECHO_EN
    check("miso_idle", {31'd0, spi_miso}, 32'd0);
    cs_begin();
    spi_byte(8'h80);
    check("miso_slot0", {24'd0, miso_cap}, 32'h00);
    spi_byte(8'h3C);
    check("miso_slot1", {24'd0, miso_cap}, 32'h80);
    spi_byte(8'hC3);
    check("miso_slot2", {24'd0, miso_cap}, 32'h3C);
    cs_end();
    check("miso_after", {31'd0, spi_miso}, 32'd0);
`endif

    check("no_back_to_back_we", back2back, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_reg_loader.md
Name: spi_reg_loader

Overview:
- SPI mode-0 slave that converts serial host transactions into byte writes for the equalizer register bank (configuration byte plus ten 24-bit gains, 31 bytes).
- Sits directly upstream of the register map and drives its we/addr/data_in port.
- All SPI pins are oversampled in the clk domain. There is no second clock domain inside the block.

Parameters:
- ADDR_WIDTH, 5: width of the addr output (covers 0..30).
- NUM_REGS, 31: number of valid register addresses; valid range is 0..NUM_REGS-1.
- SYNC_STAGES, 2: flip-flop stages on each SPI input synchronizer (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- spi_sck  in  1  SPI clock, idle low; sampled on the rising edge.
- spi_cs_n  in  1  chip select, active-low.
- spi_mosi  in  1  serial data, MSB first.
- we  out  1  one-cycle write strobe to the register map.
- addr  out  ADDR_WIDTH  write address, valid while we=1.
- data_out  out  8  write data, valid while we=1.
- busy  out  1  high while a transaction is active (synchronized cs_n low).
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset: we=0, addr=0, data_out=0, busy=0, err=0, state IDLE, shift register and bit counter cleared. Reset mid-transaction abandons the frame with no write. After reset release, the block waits for a fresh cs_n falling edge.
- Inputs: each pin passes through SYNC_STAGES flip-flops. A registered copy of synced sck detects rising edges (sck_rise).
- Required ratio: f_clk >= 8*f_sck. Slower clk is unsupported.
- Frame format: command byte first.
  - Bit 7 = 1 means write.
  - Bits 6:5 are ignored.
  - Bits 4:0 = start address.
  - Data bytes follow, one write per byte.
- State machine (IDLE, CMD, DATA, DISCARD):
  - IDLE -> CMD on synced cs_n falling edge; bit counter = 0.
  - CMD: shift mosi on each sck_rise. On the 8th bit:
    - If bit7=1 and address < NUM_REGS: go to DATA and load the address pointer.
    - Otherwise: pulse err for 1 cycle and go to DISCARD.
  - DATA: shift on each sck_rise. On the 8th bit, the next cycle has we=1, addr=pointer, data_out=byte. The pointer then increments; NUM_REGS-1 wraps to 0. The bit counter resets.
  - DISCARD: ignore sck until cs_n deasserts.
  - Any state -> IDLE on synced cs_n high, from any bit count. A partial byte is discarded and causes no write and no err.
- Latency: we rises exactly 1 clk after the sck_rise that captured bit 0 of a data byte. That is SYNC_STAGES+2 clk after the pin edge.
- we is never asserted for two consecutive cycles.
- addr and data_out hold their last values when we=0.
- busy equals the synced, inverted cs_n.
- Simultaneous events: if cs_n rises in the same cycle as the 8th sck_rise, the byte is discarded. The cs_n check has priority.

Optional Feature:
- Macro SPI_MISO_ECHO_EN.
- Defined: adds port spi_miso (out, 1). spi_miso drives the previously received byte MSB first, shifted out on synced sck falling edges. The first byte of a frame echoes 0x00. spi_miso is 0 when cs_n is high and at reset. This gives the host a link check.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package eq_ctrl_pkg holds:
  - NUM_REGS = 31
  - CFG_ADDR = 0
  - GAIN_BYTES = 3
  - CMD_WRITE_BIT = 7
  - the state enum {IDLE, CMD, DATA, DISCARD}
  - these constants are shared with the register map.
- Sub-module spi_sync_edge: N-stage synchronizer with rise/fall pulse outputs. It is instantiated for sck and cs_n; mosi uses the synchronizer only.

Test Plan:
- Write 0x81 then 0xA5: expect one we with addr=1, data_out=0xA5, SYNC_STAGES+2 clk after the last sck edge; no err.
- Burst: cmd 0x9C (addr 28) then 0x11, 0x22, 0x33, 0x44: expect writes to 28, 29, 30, 0 with values 0x11, 0x22, 0x33, 0x44 (wrap).
- Invalid commands: cmd 0x9F (addr 31) -> err pulse, no we for any following bytes. Cmd 0x05 (read) -> err pulse, no we.
- Abort: cmd 0x80, 0x12, then 4 bits of the next byte, then cs_n high -> single write (0, 0x12), busy falls, no err. A new frame afterward works normally.
- Reset: assert rst mid-byte of a data phase -> all outputs 0 immediately. After release, a write to addr 0 with 0x7E succeeds.
- SPI_MISO_ECHO_EN: frame 0x80, 0x3C, 0xC3 -> miso shifts 0x00, 0x80, 0x3C in byte slots; miso is 0 while cs_n is high.
